// File: rtl/multi_scan_clk_gen_pkg.sv
// Shared types for the multi-channel scan clock generator.
// Channel state encoding and run-mode constants.
package scan_clk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DELAY = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    FIN   = 3'd4
  } ch_state_t;

  localparam logic MODE_FREE  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/multi_scan_clk_gen_if.sv
// Control/status and clock-output bundle of the scan clock generator.
// dbg_state exposes every channel FSM state for observation.
interface multi_scan_clk_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16
) ();
  import scan_clk_pkg::*;

  // Handshake: i_start is taken on any edge where o_busy is low, which also
  // latches the whole configuration; i_stop only counts while o_busy is high.
  // A run ends with o_done high for one cycle as o_busy drops.
  logic                     i_start;
  logic                     i_stop;
  logic                     i_mode;
  logic [DIV_W-1:0]         i_div;
  logic [NUM_CH*DIV_W-1:0]  i_phase;
  logic [CNT_W-1:0]         i_burst_len;
  logic [NUM_CH-1:0]        i_ch_en;
  logic                     o_busy;
  logic                     o_done;
  logic [NUM_CH-1:0]        o_scan_clk_p;
  logic [NUM_CH-1:0]        o_scan_clk_n;
  ch_state_t [NUM_CH-1:0]   dbg_state;

  modport master (
    output i_start, i_stop, i_mode, i_div, i_phase, i_burst_len, i_ch_en,
    input  o_busy, o_done, o_scan_clk_p, o_scan_clk_n, dbg_state
  );

  modport slave (
    input  i_start, i_stop, i_mode, i_div, i_phase, i_burst_len, i_ch_en,
    output o_busy, o_done, o_scan_clk_p, o_scan_clk_n, dbg_state
  );

endinterface

// File: rtl/multi_scan_clk_gen_channel.sv
// One scan clock channel: phase delay, then div-cycle high/low pulses
// until the burst count is reached or a stop request lands on a low end.
module scan_clk_channel
  import scan_clk_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_start,
  input  logic             stop_req,
  input  logic             run_clear,
  input  logic             en,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  input  logic [CNT_W-1:0] len,
  output logic             p,
  output logic             n,
  output logic             fin,
  output ch_state_t        state
);

  ch_state_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_m1;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] pulses_q, pulses_d;
  logic [CNT_W-1:0] pulses_inc;
  logic             mode_q;
  logic             p_q, n_q;
  logic             out_of_pulses;
  logic             take_start;

  assign take_start    = run_start && (state_q == IDLE);
  assign div_m1        = div_q - DIV_W'(1);
  assign pulses_inc    = (pulses_q == '1) ? pulses_q : pulses_q + CNT_W'(1);
  assign out_of_pulses = (mode_q == MODE_BURST) && (pulses_q >= len_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulses_d = pulses_q;
    fin      = 1'b0;
    case (state_q)
      IDLE: begin
        if (take_start) begin
          state_d  = en ? DELAY : FIN;
          cnt_d    = phase;
          pulses_d = '0;
        end
      end
      DELAY: begin
        if (stop_req) begin
          state_d = FIN;
        end else if (cnt_q == '0) begin
          if (out_of_pulses) begin
            state_d = FIN;
          end else begin
            state_d  = HIGH;
            cnt_d    = div_m1;
            pulses_d = pulses_inc;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      HIGH: begin
        // A stop never cuts a high phase short; it is honoured at a low end.
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = div_m1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          if (stop_req || out_of_pulses) begin
            state_d = FIN;
          end else begin
            state_d  = HIGH;
            cnt_d    = div_m1;
            pulses_d = pulses_inc;
          end
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      FIN:     state_d = FIN;
      default: state_d = IDLE;
    endcase
    // fin looks ahead so the top can end the run on the arrival edge itself.
    fin = (state_d == FIN);
    if (run_clear) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pulses_q <= '0;
      div_q    <= DIV_W'(1);
      len_q    <= '0;
      mode_q   <= MODE_FREE;
      p_q      <= 1'b0;
      n_q      <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulses_q <= pulses_d;
      if (take_start) begin
        div_q  <= (div == '0) ? DIV_W'(1) : div;
        len_q  <= len;
        mode_q <= mode;
      end
      p_q <= (state_d == HIGH);
      n_q <= (state_d != HIGH);
    end
  end

  assign p     = p_q;
  assign n     = n_q;
  assign state = state_q;

endmodule

// File: rtl/multi_scan_clk_gen.sv
// Multi-channel scan clock generator: run handshake, stop latch and
// completion detection around NUM_CH independent channel FSMs.
module multi_scan_clk_gen
  import scan_clk_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  multi_scan_clk_gen_if.slave  bus
);

  logic                   busy_q;
  logic                   done_q;
  logic                   stop_lat_q;
  logic                   run_start;
  logic                   run_clear;
  logic                   stop_req;
  logic [NUM_CH-1:0]      fin_v;
  logic [NUM_CH-1:0]      p_v;
  logic [NUM_CH-1:0]      n_v;
  ch_state_t [NUM_CH-1:0] st_v;

  assign run_start = bus.i_start && !busy_q;
  assign run_clear = busy_q && (&fin_v);
  // The live stop input is included so a channel reacts on the sampling edge.
  assign stop_req  = busy_q && (stop_lat_q || bus.i_stop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stop_lat_q <= 1'b0;
    end else begin
      done_q <= run_clear;
      if (run_start) begin
        busy_q     <= 1'b1;
        stop_lat_q <= 1'b0;
      end else if (run_clear) begin
        busy_q     <= 1'b0;
        stop_lat_q <= 1'b0;
      end else if (busy_q && bus.i_stop) begin
        stop_lat_q <= 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    scan_clk_channel #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .run_start (run_start),
      .stop_req  (stop_req),
      .run_clear (run_clear),
      .en        (bus.i_ch_en[c]),
      .mode      (bus.i_mode),
      .div       (bus.i_div),
      .phase     (bus.i_phase[c*DIV_W +: DIV_W]),
      .len       (bus.i_burst_len),
      .p         (p_v[c]),
      .n         (n_v[c]),
      .fin       (fin_v[c]),
      .state     (st_v[c])
    );
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_scan_clk_p = p_v;
  assign bus.o_scan_clk_n = n_v;
  assign bus.dbg_state    = st_v;

endmodule

// File: tb/tb_multi_scan_clk_gen.sv
// Bench for multi_scan_clk_gen: a reference model turns each run's config
// into an expected per-cycle waveform queue that a monitor checks.
module tb_multi_scan_clk_gen;
  import scan_clk_pkg::*;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 16;
  localparam int CNT_W  = 16;
  localparam int PH_W   = NUM_CH * DIV_W;
  localparam int W      = NUM_CH + 2;   // {p, busy, done}

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  logic [W-1:0] exp_q[$];

  multi_scan_clk_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  multi_scan_clk_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, exp_q size=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  function automatic void chk_wave(string name, logic [W-1:0] got, logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got p=%b busy=%b done=%b, expected p=%b busy=%b done=%b",
               name, cyc, got[W-1:2], got[1], got[0], exp[W-1:2], exp[1], exp[0]);
    end
  endfunction

  function automatic void chk_n(logic [NUM_CH-1:0] p, logic [NUM_CH-1:0] n);
    checks++;
    if (n !== ~p) begin
      errors++;
      $display("FAIL clk_n cycle %0d: got n=%b, expected n=%b", cyc, n, ~p);
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    act = {bus.o_scan_clk_p, bus.o_busy, bus.o_done};
    chk_n(bus.o_scan_clk_p, bus.o_scan_clk_n);
    if (!rst_n) begin
      chk_wave("reset_hold", act, W'(0));
    end else if (exp_q.size() > 0) begin
      chk_wave("run_wave", act, exp_q.pop_front());
    end else begin
      chk_wave("idle", act, W'(0));
    end
  end

  // ---------------- reference model ----------------
  // Times are edges relative to the accepting edge (edge 0). Channel c
  // rises at 1+P+2D*j; at each decision edge it ends if a stop has been
  // seen by then or the burst count is used up.
  task automatic push_model(input logic mode, input int div, input logic [PH_W-1:0] phase,
                            input int len, input logic [NUM_CH-1:0] mask,
                            input bit has_stop, input int e, output int done_rel);
    int dd;
    int fin_t [NUM_CH];
    int hs    [NUM_CH][64];
    int hn    [NUM_CH];
    logic [NUM_CH-1:0] pv;
    dd = (div == 0) ? 1 : div;
    for (int c = 0; c < NUM_CH; c++) begin
      int ph;
      int t;
      ph    = int'(phase[c*DIV_W +: DIV_W]);
      hn[c] = 0;
      if (!mask[c]) begin
        fin_t[c] = 0;
      end else if (has_stop && e <= 1 + ph) begin
        fin_t[c] = e;
      end else begin
        t = 1 + ph;
        while (hn[c] < 64) begin
          if (has_stop && e <= t) break;
          if (mode == MODE_BURST && hn[c] >= len) break;
          hs[c][hn[c]] = t;
          hn[c]++;
          t += 2 * dd;
        end
        fin_t[c] = t;
      end
    end
    done_rel = 1;
    for (int c = 0; c < NUM_CH; c++) if (fin_t[c] > done_rel) done_rel = fin_t[c];
    for (int cy = 0; cy <= done_rel; cy++) begin
      pv = '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int j = 0; j < hn[c]; j++)
          if (cy >= hs[c][j] && cy < hs[c][j] + dd && cy < done_rel) pv[c] = 1'b1;
      exp_q.push_back({pv, (cy < done_rel), (cy == done_rel)});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic scramble();
    bus.i_mode      = 1'($urandom_range(0, 1));
    bus.i_div       = DIV_W'($urandom_range(0, 7));
    bus.i_phase     = PH_W'($urandom);
    bus.i_burst_len = CNT_W'($urandom_range(0, 9));
    bus.i_ch_en     = NUM_CH'($urandom);
  endtask

  // Called just after a rising edge; returns just after the completion edge.
  task automatic run(input logic mode, input int div, input logic [PH_W-1:0] phase,
                     input int len, input logic [NUM_CH-1:0] mask, input bit has_stop,
                     input int e, input bit glitch, input bit stop_with_start);
    int done_rel;
    bus.i_start     = 1'b1;
    bus.i_stop      = stop_with_start;
    bus.i_mode      = mode;
    bus.i_div       = DIV_W'(div);
    bus.i_phase     = phase;
    bus.i_burst_len = CNT_W'(len);
    bus.i_ch_en     = mask;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    push_model(mode, div, phase, len, mask, has_stop, e, done_rel);
    for (int r = 0; r < done_rel; r++) begin
      scramble();
      bus.i_stop  = has_stop && (r == e - 1);
      bus.i_start = glitch && (r == 1);
      @(posedge clk);
      #1;
    end
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_mid_run();
    int done_rel;
    bus.i_start     = 1'b1;
    bus.i_mode      = MODE_BURST;
    bus.i_div       = DIV_W'(3);
    bus.i_phase     = {DIV_W'(1), DIV_W'(0)};
    bus.i_burst_len = CNT_W'(3);
    bus.i_ch_en     = 2'b11;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    push_model(MODE_BURST, 3, {DIV_W'(1), DIV_W'(0)}, 3, 2'b11, 1'b0, 0, done_rel);
    idle(3);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_wave("reset_mid_run", {bus.o_scan_clk_p, bus.o_busy, bus.o_done}, W'(0));
    chk_n(bus.o_scan_clk_p, bus.o_scan_clk_n);
    idle(2);
    rst_n = 1'b1;
    idle(3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [PH_W-1:0] ph;
    logic            md;
    bit              hs;
    rst_n           = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_stop      = 1'b0;
    bus.i_mode      = 1'b0;
    bus.i_div       = '0;
    bus.i_phase     = '0;
    bus.i_burst_len = '0;
    bus.i_ch_en     = '0;
    checks          = 0;
    errors          = 0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // two-channel burst with phase offset
    run(MODE_BURST, 3, {DIV_W'(2), DIV_W'(0)}, 2, 2'b11, 1'b0, 0, 1'b0, 1'b0);
    idle(2);
    // free-run at clk/2, stop requested during a high cycle
    run(MODE_FREE, 1, '0, 0, 2'b01, 1'b1, 4, 1'b0, 1'b0);
    idle(1);
    // div=0 clamps to 1
    run(MODE_BURST, 0, {DIV_W'(1), DIV_W'(0)}, 2, 2'b11, 1'b0, 0, 1'b0, 1'b0);
    // zero-length burst still waits out the phase delay
    run(MODE_BURST, 2, {DIV_W'(3), DIV_W'(1)}, 0, 2'b11, 1'b0, 0, 1'b0, 1'b0);
    // empty mask completes one edge after start
    run(MODE_BURST, 2, '0, 1, 2'b00, 1'b0, 0, 1'b0, 1'b0);
    idle(1);
    // start+stop together while idle, then a start pulse while busy
    run(MODE_BURST, 2, {DIV_W'(0), DIV_W'(1)}, 2, 2'b11, 1'b0, 0, 1'b1, 1'b1);
    // back-to-back identical runs
    run(MODE_BURST, 1, {DIV_W'(1), DIV_W'(0)}, 2, 2'b11, 1'b0, 0, 1'b0, 1'b0);
    run(MODE_BURST, 1, {DIV_W'(1), DIV_W'(0)}, 2, 2'b11, 1'b0, 0, 1'b0, 1'b0);
    // stop while a channel is still in its delay
    run(MODE_FREE, 2, {DIV_W'(5), DIV_W'(0)}, 0, 2'b11, 1'b1, 3, 1'b0, 1'b0);
    idle(1);
    reset_mid_run();

    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < NUM_CH; c++) ph[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 5));
      md = 1'($urandom_range(0, 1));
      hs = (md == MODE_FREE) ? 1'b1 : ($urandom_range(0, 3) == 0);
      run(md, $urandom_range(0, 4), ph, $urandom_range(0, 3), NUM_CH'($urandom),
          hs, $urandom_range(1, 25), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_scan_clk_gen.md
Name: multi_scan_clk_gen

Overview:
Parametrised multi-channel scan clock generator, successor to the single-output fixed-divide scan clock generator in the FMC test top.
- Each of NUM_CH channels emits a complementary clock pair with a runtime-programmable half-period and a per-channel phase delay.
- Runs free-running or as a counted burst, with a start/stop/busy/done handshake.
- Sits between the board clock buffer and the FMC output buffers; driven by a test controller or register block.

Parameters:
- NUM_CH, 2, number of output clock channels (>=1)
- DIV_W, 16, width of the half-period and phase fields
- CNT_W, 16, width of the burst pulse count

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start request; sampled when idle
- i_stop  in  1  stop request; sampled when busy
- i_mode  in  1  0 = free-run, 1 = burst
- i_div  in  DIV_W  half-period in i_clk cycles, shared by all channels
- i_phase  in  NUM_CH*DIV_W  per-channel delay in i_clk cycles; ch c uses bits [c*DIV_W +: DIV_W]
- i_burst_len  in  CNT_W  high pulses per channel in burst mode
- i_ch_en  in  NUM_CH  channel enable mask
- o_busy  out  1  high while any enabled channel is active
- o_done  out  1  one-cycle pulse when a run completes
- o_scan_clk_p  out  NUM_CH  per-channel clock, true
- o_scan_clk_n  out  NUM_CH  per-channel clock, complement

Behaviour:
- Reset (async assert, sync deassert external): o_scan_clk_p = 0, o_scan_clk_n = all 1s, o_busy = 0, o_done = 0; all channels IDLE.
  - Reset mid-run aborts immediately, with no completion pulse.
- All outputs registered. o_scan_clk_n equals ~o_scan_clk_p in every cycle, including reset; it is driven from the same state, not a separate divider.
- Start: i_start=1 while o_busy=0 at edge k is accepted.
  - i_mode, i_div, i_phase, i_burst_len and i_ch_en are latched at edge k.
  - Input changes while busy are ignored.
  - o_busy=1 from edge k.
  - i_start while busy is ignored.
- Latched div of 0 is clamped to 1 (output = i_clk/2).
- Channel FSM states: IDLE, DELAY, HIGH, LOW, FIN.
  - IDLE -> DELAY on accepted start (enabled channels only). Disabled channels go straight to FIN and hold p=0.
  - DELAY lasts P = phase cycles, then enters HIGH. With P=0, p rises at edge k+1; otherwise p rises at edge k+1+P.
  - HIGH lasts D = div cycles, then LOW.
  - LOW lasts D cycles. Then:
    - HIGH again in free-run;
    - in burst mode, HIGH if fewer than L pulses have been emitted, else FIN.
  - FIN: p=0. Channel returns to IDLE when the run completes.
- Burst with L=0: enabled channels go from DELAY straight to FIN and emit no pulses. The phase delay is still honoured.
- Stop: i_stop=1 while busy, in either mode, is latched.
  - A channel in DELAY goes to FIN next edge.
  - A channel in HIGH finishes its high and low phases, then goes to FIN.
  - A channel in LOW finishes its low phase, then goes to FIN.
  - No truncated pulses are ever produced.
  - i_stop while idle is ignored. i_start and i_stop in the same idle cycle: start accepted, stop ignored.
- Completion: on the edge where the last channel reaches FIN:
  - o_done pulses high for exactly 1 cycle;
  - o_busy falls at the same edge;
  - all channels return to IDLE.
  - If the mask is all zero, completion occurs at edge k+1.
- A new start is accepted in the cycle after o_done, giving back-to-back runs.
- Arithmetic:
  - phase/div counters: DIV_W bits, down-counting; no wrap possible, since they reload from latched values.
  - pulse counter: CNT_W bits; counts up to L; saturates, never wraps.
- Free-run with no stop runs indefinitely; o_done never asserts.

Decomposition:
- Package scan_clk_pkg:
  - channel state enum (IDLE, DELAY, HIGH, LOW, FIN);
  - mode constants MODE_FREE = 1'b0, MODE_BURST = 1'b1.
- Sub-module scan_clk_channel: one channel FSM with its counters, latched div/phase/len/mode, and inputs run_start, stop_req, run_clear. Outputs p and fin.
- Top instantiates NUM_CH channels in a generate loop and holds the handshake, the stop latch, and the all-fin reduction.

Test Plan:
- Reset values: hold i_rst_n=0 -> p=0, n=all 1s, busy=0, done=0.
  - Assert reset mid-burst -> outputs return to reset values the same cycle; no done pulse.
- Burst, two channels, phase offset: div=3, phase={0,2}, L=2, mask=2'b11, start at edge k.
  - ch0 p high for cycles k+1..k+3 and k+7..k+9.
  - ch1 p high for cycles k+3..k+5 and k+9..k+11.
  - done pulse at edge k+15; busy low from k+15.
  - n = ~p throughout.
- Free-run then stop: div=1, mode=0 -> ch0 toggles every cycle (clk/2).
  - Assert stop while p=1 -> exactly one more low cycle, then FIN; done pulses 1 cycle later.
  - No pulse is shorter than 1 cycle.
- Corner configs, each -> done exactly once and no stuck busy:
  - div=0 -> behaves as div=1;
  - L=0 -> no pulses; done after phase delay + 1;
  - mask=0 -> done at k+1.
- Handshake:
  - start pulsed while busy -> ignored, config unchanged;
  - start+stop in the same idle cycle -> run starts normally;
  - start the cycle after done -> second run accepted, identical waveform.
